// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and sizing constants for the cache fill arbiter and its helpers.
//   arb_state_t : arbiter FSM state (IDLE, FILL_I, FILL_D, STORE)
//   BLOCK_WORDS : words per cache block (power of 2)
//   IDX_W       : bits needed to index a word within a block
//   BLOCK_BYTES : bytes per block (16-bit words, byte addressed)
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2,
        STORE  = 2'd3
    } arb_state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int IDX_W       = $clog2(BLOCK_WORDS);
    localparam int BLOCK_BYTES = 2 * BLOCK_WORDS;

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// -----------------------------------------------------------------------------
// fill_counter
// Issue and receive word counters for one block fill. Both counters are one bit
// wider than a word index so that BLOCK_WORDS itself is representable; neither
// counter ever advances past BLOCK_WORDS.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   clear         zero both counters (asserted on a new grant)
//   issue_en      one read was issued this cycle
//   recv_en       one read word returned this cycle
//   issue_cnt     number of words issued so far
//   recv_cnt      number of words received so far
//   issue_active  more words remain to be issued
//   last_word     the next word received completes the block
// -----------------------------------------------------------------------------
module fill_counter #(
    parameter  int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    localparam int CNT_W       = $clog2(BLOCK_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             issue_en,
    input  logic             recv_en,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] recv_cnt,
    output logic             issue_active,
    output logic             last_word
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_WORDS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (clear) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            // Saturating guards keep a stray extra strobe from overrunning.
            if (issue_en && issue_cnt < FULL)
                issue_cnt <= issue_cnt + 1'b1;
            if (recv_en && recv_cnt < FULL)
                recv_cnt <= recv_cnt + 1'b1;
        end
    end

    assign issue_active = (issue_cnt < FULL);
    assign last_word    = (recv_cnt == LAST);

endmodule

// File: rtl/cache_fill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter
// Sole owner of the single-port pipelined main memory. Grants one of: D-cache
// miss fill, D-cache write-through store, I-cache miss fill (in that priority),
// streams the block reads out one word per cycle and steers the returning words
// into the requesting cache's data array.
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   imiss_req, imiss_addr           I-cache miss (level, held until imiss_done)
//   dmiss_req, dmiss_addr           D-cache miss (level, held until dmiss_done)
//   dwr_req, dwr_addr, dwr_data     D-cache write-through store (level)
//   mem_data_out, mem_data_valid    memory read return (issue order, fixed latency)
//   mem_en, mem_wr, mem_addr,
//   mem_data_in                     memory request
//   ifill_we, dfill_we, fill_idx,
//   fill_data                       data-array write for the active fill
//   imiss_done, dmiss_done          1-cycle pulse on the last word of a fill
//   dwr_ack                         1-cycle pulse when the store goes to memory
//   busy                            arbiter not idle
// -----------------------------------------------------------------------------
module cache_fill_arbiter #(
    parameter  int ADDR_WIDTH  = 16,
    parameter  int DATA_WIDTH  = 16,
    parameter  int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imiss_req,
    input  logic [ADDR_WIDTH-1:0] imiss_addr,
    input  logic                  dmiss_req,
    input  logic [ADDR_WIDTH-1:0] dmiss_addr,
    input  logic                  dwr_req,
    input  logic [ADDR_WIDTH-1:0] dwr_addr,
    input  logic [DATA_WIDTH-1:0] dwr_data,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_data_valid,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  ifill_we,
    output logic                  dfill_we,
    output logic [IDX_W-1:0]      fill_idx,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  imiss_done,
    output logic                  dmiss_done,
    output logic                  dwr_ack,
    output logic                  busy
);

    import cache_pkg::*;

    // Byte-address mask that clears the offset within a block.
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~(ADDR_WIDTH'(2 * BLOCK_WORDS - 1));

    arb_state_t            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] st_addr_q;
    logic [DATA_WIDTH-1:0] st_data_q;

    logic [IDX_W:0]        issue_cnt;
    logic [IDX_W:0]        recv_cnt;
    logic                  issue_active;
    logic                  last_word;

    logic                  in_fill;
    logic                  grant;
    logic                  issue_en;
    logic                  recv_en;
    logic                  fill_done;

    assign in_fill   = (state == FILL_I) || (state == FILL_D);
    assign grant     = (state == IDLE) && (dmiss_req || dwr_req || imiss_req);
    assign issue_en  = in_fill && issue_active;
    // Returning words only count inside a fill, so stragglers from a fill that
    // was cut short by reset fall on the floor.
    assign recv_en   = in_fill && mem_data_valid;
    assign fill_done = recv_en && last_word;

    fill_counter #(
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_fill_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (grant),
        .issue_en     (issue_en),
        .recv_en      (recv_en),
        .issue_cnt    (issue_cnt),
        .recv_cnt     (recv_cnt),
        .issue_active (issue_active),
        .last_word    (last_word)
    );

    // Grants are never preempted; every grant returns through IDLE, which
    // gives the one idle cycle between back-to-back transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmiss_req) begin
                        state  <= FILL_D;
                        base_q <= dmiss_addr & BLOCK_MASK;
                    end else if (dwr_req) begin
                        state     <= STORE;
                        st_addr_q <= dwr_addr;
                        st_data_q <= dwr_data;
                    end else if (imiss_req) begin
                        state  <= FILL_I;
                        base_q <= imiss_addr & BLOCK_MASK;
                    end
                end
                FILL_I, FILL_D: begin
                    if (fill_done)
                        state <= IDLE;
                end
                STORE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode. Fill strobes must line up with mem_data_valid in the same
    // cycle, so they are decoded from registered state plus the valid input.
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        ifill_we    = 1'b0;
        dfill_we    = 1'b0;
        fill_idx    = '0;
        fill_data   = '0;
        imiss_done  = 1'b0;
        dmiss_done  = 1'b0;
        dwr_ack     = 1'b0;
        busy        = (state != IDLE);

        if (issue_en) begin
            mem_en   = 1'b1;
            // Blocks are aligned, so base + offset never carries out of the
            // block and needs no wrap handling.
            mem_addr = base_q + (ADDR_WIDTH'(issue_cnt) << 1);
        end

        if (state == STORE) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = st_addr_q;
            mem_data_in = st_data_q;
            dwr_ack     = 1'b1;
        end

        if (recv_en) begin
            ifill_we  = (state == FILL_I);
            dfill_we  = (state == FILL_D);
            fill_idx  = recv_cnt[IDX_W-1:0];
            fill_data = mem_data_out;
        end

        imiss_done = fill_done && (state == FILL_I);
        dmiss_done = fill_done && (state == FILL_D);
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

    localparam int L  = 4;   // memory read latency in cycles
    localparam int BW = 8;   // words per block

    logic        clk;
    logic        rst_n;
    logic        imiss_req, dmiss_req, dwr_req;
    logic [15:0] imiss_addr, dmiss_addr, dwr_addr, dwr_data;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic        ifill_we, dfill_we;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        imiss_done, dmiss_done, dwr_ack, busy;

    int checks = 0;
    int errors = 0;
    int n_ifill = 0, n_dfill = 0, n_idone = 0, n_ddone = 0;

    cache_fill_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imiss_req      (imiss_req),
        .imiss_addr     (imiss_addr),
        .dmiss_req      (dmiss_req),
        .dmiss_addr     (dmiss_addr),
        .dwr_req        (dwr_req),
        .dwr_addr       (dwr_addr),
        .dwr_data       (dwr_data),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .ifill_we       (ifill_we),
        .dfill_we       (dfill_we),
        .fill_idx       (fill_idx),
        .fill_data      (fill_data),
        .imiss_done     (imiss_done),
        .dmiss_done     (dmiss_done),
        .dwr_ack        (dwr_ack),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [15:0] fmem(input logic [15:0] ad);
        return ad ^ 16'hC35A;
    endfunction

    // Fixed-latency pipelined memory; not reset, like the real part.
    logic        mv [L];
    logic [15:0] ma [L];
    always @(posedge clk) begin
        mv[0] <= mem_en && !mem_wr;
        ma[0] <= mem_addr;
        for (int i = 1; i < L; i++) begin
            mv[i] <= mv[i-1];
            ma[i] <= ma[i-1];
        end
    end
    assign mem_data_valid = mv[L-1];
    assign mem_data_out   = fmem(ma[L-1]);

    // Transaction-level model: which transaction is active and how many cycles
    // since its grant (t = 1 is the first cycle after the grant edge).
    // kind: 0 idle, 1 I fill, 2 D fill, 3 store.
    int          kind, t;
    logic [15:0] mbase, msa, msd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind <= 0;
            t    <= 0;
        end else if (kind != 0) begin
            if (t >= ((kind == 3) ? 1 : BW + L)) kind <= 0;
            t <= t + 1;
        end else if (dmiss_req) begin
            kind <= 2; t <= 1; mbase <= dmiss_addr & 16'hFFF0;
        end else if (dwr_req) begin
            kind <= 3; t <= 1; msa <= dwr_addr; msd <= dwr_data;
        end else if (imiss_req) begin
            kind <= 1; t <= 1; mbase <= imiss_addr & 16'hFFF0;
        end
    end

    task automatic compare_cycle();
        logic        e_en, e_wr, e_iwe, e_dwe, e_id, e_dd, e_ack, e_busy, e_rcv;
        logic [15:0] e_addr, e_din, e_fd, a_addr, a_din, a_fd;
        logic [2:0]  e_idx, a_idx;
        logic [58:0] ev, av;
        {e_en, e_wr, e_iwe, e_dwe, e_id, e_dd, e_ack, e_busy, e_rcv} = '0;
        e_addr = '0; e_din = '0; e_fd = '0; e_idx = '0;
        if (kind == 3) begin
            e_en = 1; e_wr = 1; e_ack = 1; e_busy = 1; e_addr = msa; e_din = msd;
        end else if (kind != 0) begin
            e_busy = 1;
            if (t >= 1 && t <= BW) begin
                e_en = 1; e_addr = mbase + 16'(2 * (t - 1));
            end
            if (t >= 1 + L && t <= BW + L) begin
                e_rcv = 1;
                e_idx = 3'(t - 1 - L);
                e_fd  = fmem(mbase + 16'(2 * (t - 1 - L)));
                if (kind == 1) e_iwe = 1; else e_dwe = 1;
                if (t == BW + L) begin
                    if (kind == 1) e_id = 1; else e_dd = 1;
                end
            end
        end
        // Address/data/index only matter when their strobe is expected.
        a_addr = e_en  ? mem_addr    : e_addr;
        a_din  = e_wr  ? mem_data_in : e_din;
        a_idx  = e_rcv ? fill_idx    : e_idx;
        a_fd   = e_rcv ? fill_data   : e_fd;
        ev = {e_en, e_wr, e_iwe, e_dwe, e_id, e_dd, e_ack, e_busy, e_addr, e_din, e_idx, e_fd};
        av = {mem_en, mem_wr, ifill_we, dfill_we, imiss_done, dmiss_done, dwr_ack, busy,
              a_addr, a_din, a_idx, a_fd};
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL cycle_model @%0t: got %h want %h (en,wr,iwe,dwe,idone,ddone,ack,busy|addr|din|idx|data)",
                     $time, av, ev);
        end
    endtask

    task automatic checker_loop();
        forever begin
            @(posedge clk);
            #1;
            if (ifill_we)   n_ifill++;
            if (dfill_we)   n_dfill++;
            if (imiss_done) n_idone++;
            if (dmiss_done) n_ddone++;
            if (rst_n || kind == 0) compare_cycle();
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // which: 0 imiss_done, 1 dmiss_done, 2 dwr_ack
    task automatic wait_sig(input int which, input int budget, input string nm);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            next_cyc();
            if ((which == 0 && imiss_done) || (which == 1 && dmiss_done) || (which == 2 && dwr_ack)) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: no pulse within %0d cycles, want one", nm, budget);
        end
    endtask

    task automatic stimulus();
        int nd, dd;
        rst_n = 0; imiss_req = 0; dmiss_req = 0; dwr_req = 0;
        imiss_addr = 0; dmiss_addr = 0; dwr_addr = 0; dwr_data = 0;
        repeat (6) next_cyc();
        lit("reset_busy", busy, 0);
        lit("reset_mem_en", mem_en, 0);
        lit("reset_mem_addr", mem_addr, 0);
        @(negedge clk); rst_n = 1;
        repeat (2) next_cyc();

        // 1: basic I fill, latency 4
        @(negedge clk); imiss_addr = 16'h0046; imiss_req = 1;
        next_cyc();                                   // cycle 1
        lit("t1_c1_addr", mem_addr, 16'h0040);
        lit("t1_c1_en", mem_en, 1);
        repeat (3) next_cyc();                        // cycle 4
        lit("t1_c4_iwe", ifill_we, 0);
        next_cyc();                                   // cycle 5
        lit("t1_c5_iwe", ifill_we, 1);
        lit("t1_c5_idx", fill_idx, 0);
        repeat (3) next_cyc();                        // cycle 8
        lit("t1_c8_addr", mem_addr, 16'h004E);
        lit("t1_c8_idx", fill_idx, 3);
        next_cyc();                                   // cycle 9
        lit("t1_c9_en", mem_en, 0);
        repeat (2) next_cyc();                        // cycle 11
        lit("t1_c11_done", imiss_done, 0);
        next_cyc();                                   // cycle 12
        lit("t1_c12_done", imiss_done, 1);
        lit("t1_c12_idx", fill_idx, 7);
        lit("t1_c12_data", fill_data, 16'h004E ^ 16'hC35A);
        @(negedge clk); imiss_req = 0;
        next_cyc();                                   // cycle 13
        lit("t1_c13_done", imiss_done, 0);
        lit("t1_c13_busy", busy, 0);
        repeat (2) next_cyc();

        // 2: D beats I, then I after one idle cycle
        @(negedge clk); imiss_addr = 16'h0088; imiss_req = 1; dmiss_addr = 16'h1234; dmiss_req = 1;
        next_cyc();
        lit("t2_c1_addr", mem_addr, 16'h1230);
        lit("t2_c1_wr", mem_wr, 0);
        wait_sig(1, 20, "t2_dmiss_done");
        @(negedge clk); dmiss_req = 0;
        next_cyc();
        lit("t2_idle_busy", busy, 0);
        next_cyc();
        lit("t2_i_addr", mem_addr, 16'h0080);
        wait_sig(0, 20, "t2_imiss_done");
        @(negedge clk); imiss_req = 0;
        repeat (2) next_cyc();

        // 3: store beats I fill
        @(negedge clk); dwr_addr = 16'h2002; dwr_data = 16'hBEEF; dwr_req = 1;
        imiss_addr = 16'h0100; imiss_req = 1;
        next_cyc();
        lit("t3_wr", mem_wr, 1);
        lit("t3_addr", mem_addr, 16'h2002);
        lit("t3_din", mem_data_in, 16'hBEEF);
        lit("t3_ack", dwr_ack, 1);
        @(negedge clk); dwr_req = 0;
        next_cyc();
        lit("t3_ack_off", dwr_ack, 0);
        lit("t3_idle", busy, 0);
        next_cyc();
        lit("t3_i_addr", mem_addr, 16'h0100);
        lit("t3_i_wr", mem_wr, 0);
        wait_sig(0, 20, "t3_imiss_done");
        @(negedge clk); imiss_req = 0;
        repeat (2) next_cyc();

        // 4: reset in cycle 6 of a D fill
        @(negedge clk); dmiss_addr = 16'h3000; dmiss_req = 1;
        dd = n_ddone;
        next_cyc();
        repeat (5) next_cyc();                        // cycle 6
        #2; rst_n = 0; dmiss_req = 0;
        #1;
        lit("t4_rst_en", mem_en, 0);
        lit("t4_rst_busy", busy, 0);
        lit("t4_rst_dwe", dfill_we, 0);
        lit("t4_rst_addr", mem_addr, 0);
        nd = n_dfill;
        @(negedge clk); @(negedge clk); rst_n = 1;
        repeat (10) next_cyc();
        lit("t4_no_dfill", n_dfill, nd);
        lit("t4_no_ddone", n_ddone, dd);
        @(negedge clk); imiss_addr = 16'h0200; imiss_req = 1;
        next_cyc();
        lit("t4_i_addr", mem_addr, 16'h0200);
        wait_sig(0, 20, "t4_imiss_done");
        @(negedge clk); imiss_req = 0;
        repeat (2) next_cyc();

        // 5: top-of-memory block, no wrap
        @(negedge clk); dmiss_addr = 16'hFFFC; dmiss_req = 1;
        next_cyc();
        lit("t5_c1_addr", mem_addr, 16'hFFF0);
        repeat (7) next_cyc();
        lit("t5_c8_addr", mem_addr, 16'hFFFE);
        next_cyc();
        lit("t5_c9_en", mem_en, 0);
        wait_sig(1, 20, "t5_dmiss_done");
        @(negedge clk); dmiss_req = 0;
        repeat (2) next_cyc();

        // 6: request dropped mid-fill still completes
        @(negedge clk); dmiss_addr = 16'h0500; dmiss_req = 1;
        nd = n_dfill; dd = n_ddone;
        next_cyc();
        repeat (2) next_cyc();                        // cycle 3
        @(negedge clk); dmiss_req = 0;
        repeat (16) next_cyc();
        lit("t6_words", n_dfill - nd, 8);
        lit("t6_done", n_ddone - dd, 1);
        lit("t6_idle", busy, 0);
    endtask

    initial begin
        fork
            checker_loop();
            stimulus();
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
